// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and counter sizing for the sequential divider
package div_pkg;

   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

   localparam int DIV_DEF_WIDTH = 64;

   function automatic int cnt_w(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/adder.sv
// adder: W-bit ripple-carry adder with carry-in
module adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum
);

   logic [W-1:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign sum[i] = a[i] ^ b[i] ^ c[i];
      if (i < W - 1) begin : g_carry
         assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

endmodule

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (trial subtract via adder)
module div_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] rem,
   input  logic         bin,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_n,
   output logic         qbit
);

   logic [W:0] trial;

   adder #(.W(W + 1)) u_add (
      .a  ({rem, bin}),
      .b  (~{1'b0, divisor}),
      .cin(1'b1),
      .sum(trial)
   );

   assign qbit  = ~trial[W];
   assign rem_n = qbit ? trial[W-1:0] : {rem[W-2:0], bin};

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, valid/ready on both sides.
// Define DIV_SIGNED_EN to honour signed_op (truncating two's-complement divide).
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             signed_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_w(WIDTH);

   if (WIDTH <= 1) begin : g_bad_width
      $error("seq_divider: WIDTH must be > 1");
   end

   div_state_t       state, state_n;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvs, rem_step, q_step, q_fin, rem_fin, a_mag, d_mag;
   logic             qb, accept, last;

   assign accept = in_ready & in_valid;
   assign last   = (state == DIV_BUSY) && (cnt == '0);

   div_step #(.W(WIDTH)) u_step (
      .rem    (remainder),
      .bin    (quotient[WIDTH-1]),
      .divisor(dvs),
      .rem_n  (rem_step),
      .qbit   (qb)
   );

   assign q_step = {quotient[WIDTH-2:0], qb};

`ifdef DIV_SIGNED_EN
   logic sa, sd, qneg, rneg;
   always_comb begin
      sa      = signed_op & dividend[WIDTH-1];
      sd      = signed_op & divisor[WIDTH-1];
      a_mag   = sa ? -dividend : dividend;
      d_mag   = sd ? -divisor : divisor;
      q_fin   = (last && qneg) ? -q_step : q_step;
      rem_fin = (last && rneg) ? -rem_step : rem_step;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         qneg <= 1'b0;
         rneg <= 1'b0;
      end else if (accept) begin
         qneg <= sa ^ sd;
         rneg <= sa;
      end
   end
`else
   logic unused_signed;
   assign unused_signed = signed_op;
   assign a_mag         = dividend;
   assign d_mag         = divisor;
   assign q_fin         = q_step;
   assign rem_fin       = rem_step;
`endif

   always_comb begin
      in_ready  = (state == DIV_IDLE);
      out_valid = (state == DIV_DONE);
      state_n   = accept                               ? ((divisor == '0) ? DIV_DONE : DIV_BUSY) :
                  last                                 ? DIV_DONE :
                  (state == DIV_DONE && out_ready)     ? DIV_IDLE : state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= DIV_IDLE;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         dvs         <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            div_by_zero <= (divisor == '0);
            cnt         <= CW'(WIDTH - 1);
            dvs         <= d_mag;
            quotient    <= (divisor == '0) ? '1 : a_mag;
            remainder   <= (divisor == '0) ? dividend : '0;
         end else if (state == DIV_BUSY) begin
            cnt       <= cnt - 1'b1;
            quotient  <= q_fin;
            remainder <= rem_fin;
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard-based self-checking bench for seq_divider (WIDTH=8)
module tb_seq_divider;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
   } exp_t;

   logic       clk = 0, reset = 1, in_valid = 0, signed_op = 0, out_ready = 0;
   logic [7:0] dividend = 0, divisor = 0;
   logic       in_ready, out_valid, div_by_zero;
   logic [7:0] quotient, remainder;

   exp_t scb[$];
   int   n_checks = 0, n_fail = 0;

   seq_divider #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .signed_op(signed_op),
      .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
      .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
      exp_t e;
      int   sa, sd;
      sa   = $signed(a);
      sd   = $signed(b);
      e.dz = (b == 0);
      if (b == 0) begin
         e.q = 8'hFF;
         e.r = a;
      end
`ifdef DIV_SIGNED_EN
      else if (s) begin
         e.q = 8'(sa / sd);
         e.r = 8'(sa % sd);
      end
`endif
      else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
      int n = 0;
      dividend  = a;
      divisor   = b;
      signed_op = s;
      in_valid  = 1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 0;
      scb.push_back(model(a, b, s));
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!out_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({in_ready, out_valid, div_by_zero, quotient, remainder} !== {3'b100, 16'h0}) begin
         n_fail++;
         $display("FAIL reset_state: rdy=%b vld=%b dz=%b q=%h r=%h required 1 0 0 00 00",
                  in_ready, out_valid, div_by_zero, quotient, remainder);
      end
      reset = 0;
   endtask

   task automatic test_unsigned();
      exp_t e;
      int   n;
      out_ready = 0;
      issue(8'd100, 8'd7, 0);
      wait_valid(n);
      e = scb.pop_front();
      n_checks++;
      if (n !== 8) begin
         n_fail++;
         $display("FAIL unsigned_latency: %0d cycles required 8", n);
      end
      n_checks++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} || e.q !== 8'd14 || e.r !== 8'd2) begin
         n_fail++;
         $display("FAIL unsigned_100_7: q=%0d r=%0d dz=%b required q=%0d r=%0d dz=%b",
                  quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL unsigned_release: rdy=%b vld=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_div_zero();
      exp_t e;
      int   n;
      out_ready = 0;
      issue(8'd55, 8'd0, 0);
      wait_valid(n);
      e = scb.pop_front();
      n_checks++;
      if (n !== 0) begin
         n_fail++;
         $display("FAIL div0_latency: %0d extra cycles required 0", n);
      end
      n_checks++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} || div_by_zero !== 1'b1) begin
         n_fail++;
         $display("FAIL div0_55: q=%h r=%0d dz=%b required q=%h r=%0d dz=%b",
                  quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   n;
      out_ready = 0;
      issue(8'd200, 8'd3, 0);
      wait_valid(n);
      e = scb.pop_front();
      n_checks++;
      if ({quotient, remainder} !== {e.q, e.r} || e.q !== 8'd66) begin
         n_fail++;
         $display("FAIL bp_result: q=%0d r=%0d required q=%0d r=%0d", quotient, remainder, e.q, e.r);
      end
      dividend = 8'd5;
      divisor  = 8'd1;
      in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({out_valid, in_ready, quotient, remainder} !== {2'b10, e.q, e.r}) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: vld=%b rdy=%b q=%0d r=%0d required 1 0 %0d %0d",
                     i, out_valid, in_ready, quotient, remainder, e.q, e.r);
         end
      end
      in_valid  = 0;
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_idle: rdy=%b vld=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_op();
      exp_t e;
      int   n;
      out_ready = 0;
      issue(8'd255, 8'd1, 0);
      void'(scb.pop_front());
      repeat (3) @(posedge clk);
      #1;
      reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
      n_checks++;
      if ({in_ready, out_valid, div_by_zero, quotient, remainder} !== {3'b100, 16'h0}) begin
         n_fail++;
         $display("FAIL abort_state: rdy=%b vld=%b dz=%b q=%h r=%h required 1 0 0 00 00",
                  in_ready, out_valid, div_by_zero, quotient, remainder);
      end
      out_ready = 1;
      issue(8'd9, 8'd3, 0);
      wait_valid(n);
      e = scb.pop_front();
      n_checks++;
      if ({quotient, remainder} !== {e.q, e.r} || e.q !== 8'd3) begin
         n_fail++;
         $display("FAIL after_abort_9_3: q=%0d r=%0d required q=%0d r=%0d", quotient, remainder, e.q, e.r);
      end
      @(posedge clk);
      #1;
      out_ready = 0;
   endtask

   task automatic test_signed();
      logic [7:0] a[3] = '{8'hF9, 8'h80, 8'hF9};
      logic [7:0] b[3] = '{8'h02, 8'hFF, 8'h00};
      exp_t       e;
      int         n;
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         issue(a[i], b[i], 1);
         wait_valid(n);
         e = scb.pop_front();
         n_checks++;
         if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
            n_fail++;
            $display("FAIL signed_%h_%h: q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                     a[i], b[i], quotient, remainder, div_by_zero, e.q, e.r, e.dz);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, b;
      logic       s;
      exp_t       e;
      int         n;
      out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         a = 8'($urandom_range(0, 255));
         b = (i == 4) ? 8'd0 : 8'($urandom_range(0, 255));
         s = 1'($urandom_range(0, 1));
         issue(a, b, s);
         wait_valid(n);
         e = scb.pop_front();
         n_checks++;
         if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
            n_fail++;
            $display("FAIL b2b_%0d %h/%h s=%b: q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                     i, a, b, s, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
         end
         @(posedge clk);
         #1;
         n_checks++;
         if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_ready_%0d: rdy=%b vld=%b required 1 0", i, in_ready, out_valid);
         end
      end
      out_ready = 0;
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_div_zero();
      test_backpressure();
      test_reset_mid_op();
      test_signed();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
